lfsr_rng: RTL
=============

Name: lfsr_rng

Overview:
- Parametrised Galois LFSR random-number generator for the tile-flip game logic. Produces uniformly distributed values in [0, RANGE-1]; the default RANGE=9 matches a 3x3 tile grid.
- Can free-run every clock so that player timing adds entropy. Supports runtime reseeding.
- Delivers one range-limited value per request through a req/busy/valid handshake, using bounded rejection sampling.

Parameters:
- WIDTH, 16, LFSR register width.
- TAPS, 16'hB400, Galois feedback mask (WIDTH bits). The default is maximal length, period 65535.
- SEED, 16'h0001, reset value of the LFSR. Must be nonzero.
- OUT_W, 4, width of the sample and of rand_out. Constraint: OUT_W <= WIDTH.
- RANGE, 9, number of legal outputs. Constraint: 2^(OUT_W-1) < RANGE <= 2^OUT_W.
- MAX_TRIES, 8, maximum DRAW evaluations per request. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- run  in  1  advance the LFSR every cycle while high (entropy mode)
- seed_load  in  1  load seed_in into the LFSR this cycle
- seed_in  in  WIDTH  seed value
- req  in  1  request one random value; sampled only in IDLE
- busy  out  1  high while in DRAW
- rand_valid  out  1  one-cycle pulse: rand_out updated
- rand_out  out  OUT_W  last accepted value, held until the next accept
- lfsr_state  out  WIDTH  current LFSR register (debug)

Behaviour:
- Reset (asynchronous):
  - lfsr = SEED, state = IDLE, tries = 0.
  - busy = 0, rand_valid = 0, rand_out = 0.
- Step function (Galois, right shift): next = (s >> 1) ^ (s[0] ? TAPS : 0).
- Step condition, evaluated at each edge: the LFSR steps when (run == 1 OR state == DRAW) AND seed_load == 0.
- Seed load:
  - seed_load has priority over stepping.
  - lfsr <= seed_in, except when seed_in == 0, in which case lfsr <= 1. A zero lock-up state is therefore unreachable.
- States:
  - IDLE: busy = 0. If req == 1 and seed_load == 0, go to DRAW with tries = 0 and busy = 1. The LFSR does not step at this edge unless run = 1.
  - DRAW: on each edge, sample = lfsr[OUT_W-1:0], taken from the pre-step value.
    - If sample < RANGE: rand_out <= sample, rand_valid <= 1, go to IDLE.
    - Else if tries == MAX_TRIES-1: rand_out <= sample - RANGE (always < RANGE by the parameter constraint), rand_valid <= 1, go to IDLE.
    - Else: tries <= tries + 1, stay in DRAW.
    - The LFSR steps on every DRAW edge, whether the sample is accepted or rejected.
- Latency:
  - The req-high cycle is followed by one DRAW cycle per evaluation.
  - rand_valid is high in the cycle after the accepting edge.
  - Minimum is 2 clocks from req high to rand_valid high; maximum is MAX_TRIES + 1.
- rand_valid is high for exactly 1 cycle per completed request. It is never high while busy = 1.
- req while busy is ignored and not queued. req held high continuously re-triggers from IDLE at the edge after each valid, so rand_valid and DRAW entry can coincide.
- seed_load during DRAW aborts the draw: state goes to IDLE, tries goes to 0, no rand_valid is issued, and rand_out is unchanged. The seed still loads.
- seed_load and req together in IDLE: the seed loads and req is ignored.
- Reset mid-DRAW: all registers return to their reset values immediately. No rand_valid is issued.
- The tries counter is $clog2(MAX_TRIES)+1 bits wide and saturates by construction.

Test Plan:
- Reset, run = 0, req pulse of 1 cycle:
  - DRAW evaluates 0x0001, low nibble 1 < 9, so rand_out = 1 and rand_valid pulses 2 clocks after req.
  - lfsr_state = 0xB400 afterwards.
- Free-run:
  - Reset, run = 1: lfsr_state sequence is 0x0001 → 0xB400 → 0x5A00 → 0x2D00 → 0x1680.
  - After 65535 steps it returns to 0x0001 and is never 0.
- Rejection:
  - seed_load with 0xB40F, then req.
  - First sample 15 is rejected; lfsr becomes 0xEE07; second sample 7 is accepted.
  - Result: rand_out = 7, busy high for 2 cycles.
- Fallback:
  - Build with MAX_TRIES = 1; seed_load 0x000F, then req.
  - Sample 15 with tries at its limit gives rand_out = 6 (15 - 9) after a single DRAW cycle.
- Zero seed and abort:
  - seed_load with seed_in = 0 gives lfsr_state = 0x0001.
  - Issue req, then assert seed_load during DRAW: busy drops next cycle, no rand_valid, and rand_out keeps its prior value.
- Statistics: 9000 back-to-back requests with run = 1 → every value 0..8 appears; no value ≥ 9; no rand_valid while busy.

Source files
------------

// File: rtl/lfsr_rng_if.sv
// Handshake and data bundle for the lfsr_rng random-number generator.
// master drives the control side (game logic / bench), slave is the generator.
interface lfsr_rng_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4
);
    logic             run;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             busy;
    logic             rand_valid;
    logic [OUT_W-1:0] rand_out;
    logic [WIDTH-1:0] lfsr_state;

    modport master (
        output run, seed_load, seed_in, req,
        input  busy, rand_valid, rand_out, lfsr_state
    );

    modport slave (
        input  run, seed_load, seed_in, req,
        output busy, rand_valid, rand_out, lfsr_state
    );
endinterface

// File: rtl/lfsr_rng.sv
// Galois LFSR random-number generator with range-limited output.
// A request draws LFSR samples until one falls below RANGE, giving up after
// MAX_TRIES draws by folding the last sample back into range. The LFSR can
// also free-run so that the timing of requests adds entropy.
module lfsr_rng #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'h0001,
    parameter int               OUT_W     = 4,
    parameter int               RANGE     = 9,
    parameter int               MAX_TRIES = 8
) (
    input logic       clk,
    input logic       reset,
    lfsr_rng_if.slave bus
);

    localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] RANGE_LO = OUT_W'(RANGE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [TRY_W-1:0] tries, tries_next;
    logic [WIDTH-1:0] lfsr, lfsr_next;
    logic [OUT_W-1:0] rand_out_q, accept_val;
    logic             rand_valid_q, accept;
    logic [OUT_W-1:0] sample;
    logic             step;

    // One right-shift Galois step: feedback mask applied when bit 0 falls out.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // Fallback mapping of a rejected sample; RANGE > 2^(OUT_W-1) keeps the
    // difference strictly below RANGE.
    function automatic logic [OUT_W-1:0] fold_sample(input logic [OUT_W-1:0] s);
        return s - RANGE_LO;
    endfunction

    // Next-state, retry counter and accept decision for the draw FSM.
    always_comb begin
        state_next = state;
        tries_next = tries;
        accept     = 1'b0;
        accept_val = rand_out_q;
        sample     = lfsr[OUT_W-1:0];
        case (state)
            IDLE: begin
                if (bus.req && !bus.seed_load) begin
                    state_next = DRAW;
                    tries_next = '0;
                end
            end
            DRAW: begin
                if (bus.seed_load) begin
                    // Reseeding abandons the draw without producing a value.
                    state_next = IDLE;
                    tries_next = '0;
                end else if ({1'b0, sample} < RANGE_X) begin
                    accept     = 1'b1;
                    accept_val = sample;
                    state_next = IDLE;
                    tries_next = '0;
                end else if (tries == LAST_TRY) begin
                    accept     = 1'b1;
                    accept_val = fold_sample(sample);
                    state_next = IDLE;
                    tries_next = '0;
                end else begin
                    tries_next = tries + TRY_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                tries_next = '0;
            end
        endcase
    end

    // LFSR update: seed load wins over stepping; a zero seed maps to 1 to avoid lock-up.
    always_comb begin
        step = (bus.run || (state == DRAW)) && !bus.seed_load;
        if (bus.seed_load) begin
            lfsr_next = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
        end else if (step) begin
            lfsr_next = galois_step(lfsr);
        end else begin
            lfsr_next = lfsr;
        end
    end

    // State, counter, LFSR and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tries        <= '0;
            lfsr         <= SEED;
            rand_out_q   <= '0;
            rand_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            tries        <= tries_next;
            lfsr         <= lfsr_next;
            rand_valid_q <= accept;
            if (accept) begin
                rand_out_q <= accept_val;
            end
        end
    end

    assign bus.busy       = (state == DRAW);
    assign bus.rand_valid = rand_valid_q;
    assign bus.rand_out   = rand_out_q;
    assign bus.lfsr_state = lfsr;

endmodule
